// File: rtl/spram_ctrl.sv
// -----------------------------------------------------------------------------
// spram_ctrl
//
// Request-side front end for a single-port RAM. It turns a valid/ready request
// channel into the RAM's csn/wen/addr/wdata strobes, and it buffers read data
// in a 2-entry in-order response FIFO that has its own valid/ready channel.
// The RAM is strapped read-first with an asynchronous read, so mem_rdata
// follows mem_addr within the same cycle and is sampled at the accept edge.
//
// Optional feature (macro SPRAM_CTRL_INIT_EN):
//   After reset, an init sequencer writes INIT_VALUE to every RAM location,
//   one address per cycle, before requests are accepted. If the macro is not
//   defined there is no INIT phase and RAM contents are unknown until written.
//
// Ports:
//   clk        in   clock, rising edge
//   rstn       in   asynchronous active-low reset
//   req_valid  in   request present
//   req_ready  out  request accepted this cycle (when req_valid is high)
//   req_we     in   1 = write, 0 = read
//   req_addr   in   request address            [ADDR_WIDTH]
//   req_wdata  in   request write data         [DATA_WIDTH]
//   rsp_valid  out  read response present
//   rsp_ready  in   consumer takes the response this cycle
//   rsp_rdata  out  head of response FIFO, 0 when empty [DATA_WIDTH]
//   mem_csn    out  RAM chip select, active low
//   mem_wen    out  RAM write enable, active low
//   mem_addr   out  RAM address                [ADDR_WIDTH]
//   mem_wdata  out  RAM write data             [DATA_WIDTH]
//   mem_mode   out  tied 0 (read-first)
//   mem_synch  out  tied 0 (asynchronous read)
//   mem_rdata  in   RAM read data              [DATA_WIDTH]
//
// States:
//   state    | meaning
//   ST_BOOT  | held in reset / first cycle after release; no RAM access
//   ST_INIT  | init sequencer writing INIT_VALUE (feature build only)
//   ST_RUN   | normal operation, requests accepted while FIFO has room
// -----------------------------------------------------------------------------
module spram_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  mem_csn,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_mode,
  output logic                  mem_synch,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Response FIFO
  logic [DATA_WIDTH-1:0] rsp_mem_q [2];
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            count_q, count_d;

  // Last driven RAM address / data, held while the RAM is idle
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;

  logic accept;
  logic push;
  logic pop;
  logic init_wr;

  assign mem_mode  = 1'b0;
  assign mem_synch = 1'b0;

`ifdef SPRAM_CTRL_INIT_EN
  // Init address counter; it is cleared whenever the FSM is outside INIT so
  // that any re-entry (e.g. reset during INIT) restarts from address 0.
  logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
  logic                  init_last;

  assign init_wr    = (state_q == ST_INIT);
  assign init_last  = (init_cnt_q == '1);
  assign init_cnt_d = init_wr ? (init_cnt_q + 1'b1) : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      init_cnt_q <= '0;
    end else begin
      init_cnt_q <= init_cnt_d;
    end
  end
`else
  assign init_wr = 1'b0;

  // INIT_VALUE only matters when the init sequencer is built in.
  logic unused_init_value;
  assign unused_init_value = ^INIT_VALUE;
`endif

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT: begin
`ifdef SPRAM_CTRL_INIT_EN
        state_d = ST_INIT;
`else
        state_d = ST_RUN;
`endif
      end
      ST_INIT: begin
`ifdef SPRAM_CTRL_INIT_EN
        if (init_last) begin
          state_d = ST_RUN;
        end
`else
        state_d = ST_RUN;
`endif
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request side. Ready depends only on state and FIFO occupancy, so a pop in
  // a full cycle only frees a slot for the following cycle.
  // ---------------------------------------------------------------------------
  assign req_ready = (state_q == ST_RUN) && (count_q < 2'd2);
  assign accept    = req_valid && req_ready;

  always_comb begin
    mem_csn   = 1'b1;
    mem_wen   = 1'b1;
    mem_addr  = mem_addr_q;
    mem_wdata = mem_wdata_q;
    if (init_wr) begin
`ifdef SPRAM_CTRL_INIT_EN
      mem_csn   = 1'b0;
      mem_wen   = 1'b0;
      mem_addr  = init_cnt_q;
      mem_wdata = INIT_VALUE;
`endif
    end else if (accept) begin
      mem_csn   = 1'b0;
      mem_wen   = ~req_we;
      mem_addr  = req_addr;
      mem_wdata = req_wdata;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      mem_addr_q  <= mem_addr;
      mem_wdata_q <= mem_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Response FIFO. Read data is captured at the accept edge straight from the
  // asynchronous RAM output.
  // ---------------------------------------------------------------------------
  assign push      = accept && !req_we;
  assign rsp_valid = (count_q != 2'd0);
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_rdata = rsp_valid ? rsp_mem_q[rd_ptr_q] : '0;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 2; i++) begin
        rsp_mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        rsp_mem_q[wr_ptr_q] <= mem_rdata;
        wr_ptr_q            <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_spram_ctrl.sv
module tb_spram_ctrl;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam logic [7:0] IV = 8'h5A;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          mem_csn, mem_wen, mem_mode, mem_synch;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  spram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_VALUE(IV)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .mem_csn(mem_csn), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_mode(mem_mode), .mem_synch(mem_synch),
    .mem_rdata(mem_rdata)
  );

  // Single-port RAM: write at the clock edge, asynchronous read.
  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk) if (!mem_csn && !mem_wen) ram[mem_addr] <= mem_wdata;
  assign mem_rdata = ram[mem_addr];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: phase (0 boot, 1 init, 2 run), shadow memory with known
  // bits, and a queue of expected responses.
  // ---------------------------------------------------------------------------
  typedef struct { logic [7:0] d; bit v; } exp_t;
  exp_t       m_q[$];
  int         m_state = 0;
  int         m_init_idx = 0;
  int         m_init_writes = 0;
  logic [7:0] shadow [DEPTH];
  bit         shadow_v [DEPTH];
  logic [AW-1:0] m_last_addr = '0;
  logic [DW-1:0] m_last_wdata = '0;
  bit         mon_en = 0;
  bit         m_ready, m_acc, m_pop;

  always @(negedge clk) begin
    if (mon_en) begin
      if (!rstn) begin
        chk("mon_rst_ready", 32'(req_ready), 32'(0));
        chk("mon_rst_rvalid", 32'(rsp_valid), 32'(0));
        chk("mon_rst_rdata", 32'(rsp_rdata), 32'(0));
        chk("mon_rst_csn", 32'(mem_csn), 32'(1));
        chk("mon_rst_wen", 32'(mem_wen), 32'(1));
        chk("mon_rst_addr", 32'(mem_addr), 32'(0));
        chk("mon_rst_wdata", 32'(mem_wdata), 32'(0));
        m_q.delete();
        m_state = 0;
        m_init_idx = 0;
        m_last_addr = '0;
        m_last_wdata = '0;
      end else begin
        m_ready = (m_state == 2) && (m_q.size() < 2);
        chk("mon_req_ready", 32'(req_ready), 32'(m_ready));
        chk("mon_rsp_valid", 32'(rsp_valid), 32'(m_q.size() != 0));
        if (m_q.size() == 0) chk("mon_rdata_empty", 32'(rsp_rdata), 32'(0));
        else if (m_q[0].v) chk("mon_rsp_rdata", 32'(rsp_rdata), 32'(m_q[0].d));
        m_acc = req_valid && m_ready;
        m_pop = rsp_ready && (m_q.size() != 0);
        if (m_state == 1) begin
          chk("mon_init_csn", 32'(mem_csn), 32'(0));
          chk("mon_init_wen", 32'(mem_wen), 32'(0));
          chk("mon_init_addr", 32'(mem_addr), 32'(m_init_idx));
          chk("mon_init_wdata", 32'(mem_wdata), 32'(IV));
          shadow[m_init_idx] = IV;
          shadow_v[m_init_idx] = 1;
          m_last_addr = AW'(m_init_idx);
          m_last_wdata = IV;
          m_init_writes++;
          if (m_init_idx == DEPTH - 1) m_state = 2;
          m_init_idx++;
        end else if (m_acc) begin
          chk("mon_acc_csn", 32'(mem_csn), 32'(0));
          chk("mon_acc_wen", 32'(mem_wen), 32'(!req_we));
          chk("mon_acc_addr", 32'(mem_addr), 32'(req_addr));
          chk("mon_acc_wdata", 32'(mem_wdata), 32'(req_wdata));
          m_last_addr = req_addr;
          m_last_wdata = req_wdata;
        end else begin
          chk("mon_idle_csn", 32'(mem_csn), 32'(1));
          chk("mon_idle_wen", 32'(mem_wen), 32'(1));
          chk("mon_idle_addr", 32'(mem_addr), 32'(m_last_addr));
          chk("mon_idle_wdata", 32'(mem_wdata), 32'(m_last_wdata));
        end
        if (m_pop) void'(m_q.pop_front());
        if (m_acc) begin
          if (req_we) begin
            shadow[req_addr] = req_wdata;
            shadow_v[req_addr] = 1;
          end else begin
            m_q.push_back('{d: shadow[req_addr], v: shadow_v[req_addr]});
          end
        end
        if (m_state == 0) begin
`ifdef SPRAM_CTRL_INIT_EN
          m_state = 1;
`else
          m_state = 2;
`endif
          m_init_idx = 0;
          m_init_writes = 0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed vectors: one record per cycle, inputs and expected outputs.
  // ---------------------------------------------------------------------------
  typedef struct {
    bit v; bit we; logic [3:0] a; logic [7:0] d; bit rr;
    bit e_ready; bit e_csn; bit e_rv; logic [7:0] e_rd;
  } vec_t;
  localparam int NV = 21;
  vec_t tbl [NV];

  task automatic wait_ready(input int budget, input string nm);
    bit ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (req_ready) ok = 1;
    end
    chk(nm, 32'(ok), 32'(1));
  endtask

  task automatic single_read(input logic [3:0] a, input logic [7:0] exp, input string nm);
    req_valid = 1; req_we = 0; req_addr = a; rsp_ready = 1;
    @(posedge clk); #1;
    req_valid = 0;
    @(negedge clk);
    chk({nm, "_valid"}, 32'(rsp_valid), 32'(1));
    chk({nm, "_data"}, 32'(rsp_rdata), 32'(exp));
    @(posedge clk); #1;
    rsp_ready = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    //          v  we a     d      rr rdy csn rv rd
    tbl[0]  = '{1, 1, 4'd3, 8'hA5, 1, 1,  0,  0, 8'h00};
    tbl[1]  = '{1, 0, 4'd3, 8'h00, 1, 1,  0,  0, 8'h00};
    tbl[2]  = '{0, 0, 4'd0, 8'h00, 1, 1,  1,  1, 8'hA5};
    tbl[3]  = '{0, 0, 4'd0, 8'h00, 0, 1,  1,  0, 8'h00};
    tbl[4]  = '{1, 1, 4'd0, 8'h11, 0, 1,  0,  0, 8'h00};
    tbl[5]  = '{1, 1, 4'd1, 8'h22, 0, 1,  0,  0, 8'h00};
    tbl[6]  = '{1, 1, 4'd2, 8'h33, 0, 1,  0,  0, 8'h00};
    tbl[7]  = '{1, 0, 4'd0, 8'h00, 0, 1,  0,  0, 8'h00};
    tbl[8]  = '{1, 0, 4'd1, 8'h00, 0, 1,  0,  1, 8'h11};
    tbl[9]  = '{1, 0, 4'd2, 8'h00, 0, 0,  1,  1, 8'h11};
    tbl[10] = '{1, 0, 4'd2, 8'h00, 0, 0,  1,  1, 8'h11};
    tbl[11] = '{1, 0, 4'd2, 8'h00, 1, 0,  1,  1, 8'h11};
    tbl[12] = '{1, 0, 4'd2, 8'h00, 0, 1,  0,  1, 8'h22};
    tbl[13] = '{0, 0, 4'd0, 8'h00, 1, 0,  1,  1, 8'h22};
    tbl[14] = '{0, 0, 4'd0, 8'h00, 1, 1,  1,  1, 8'h33};
    tbl[15] = '{0, 0, 4'd0, 8'h00, 1, 1,  1,  0, 8'h00};
    tbl[16] = '{1, 0, 4'd0, 8'h00, 0, 1,  0,  0, 8'h00};
    tbl[17] = '{1, 0, 4'd1, 8'h00, 1, 1,  0,  1, 8'h11};
    tbl[18] = '{0, 0, 4'd0, 8'h00, 0, 1,  1,  1, 8'h22};
    tbl[19] = '{0, 0, 4'd0, 8'h00, 1, 1,  1,  1, 8'h22};
    tbl[20] = '{0, 0, 4'd0, 8'h00, 1, 1,  1,  0, 8'h00};

    req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; rsp_ready = 0;

    // Reset and immediate reset values
    #1 rstn = 0; mon_en = 1;
    #1;
    chk("rst_csn", 32'(mem_csn), 32'(1));
    chk("rst_rvalid", 32'(rsp_valid), 32'(0));
    chk("rst_ready", 32'(req_ready), 32'(0));
    chk("mem_mode", 32'(mem_mode), 32'(0));
    chk("mem_synch", 32'(mem_synch), 32'(0));
    repeat (2) @(posedge clk);
    #1 rstn = 1;
    @(negedge clk);
    chk("ready_boot_cycle", 32'(req_ready), 32'(0));
`ifdef SPRAM_CTRL_INIT_EN
    wait_ready(40, "init_done");
    chk("init_write_count", 32'(m_init_writes), 32'(DEPTH));
`else
    @(negedge clk);
    chk("ready_after_rst", 32'(req_ready), 32'(1));
    chk("idle_csn_after_rst", 32'(mem_csn), 32'(1));
    chk("idle_rvalid_after_rst", 32'(rsp_valid), 32'(0));
`endif
    @(posedge clk); #1;

`ifdef SPRAM_CTRL_INIT_EN
    single_read(4'd0, IV, "init_rd0");
    single_read(4'd7, IV, "init_rd7");
    single_read(4'd15, IV, "init_rd15");
`endif

    // Table-driven vectors
    for (int i = 0; i < NV; i++) begin
      req_valid = tbl[i].v; req_we = tbl[i].we; req_addr = tbl[i].a;
      req_wdata = tbl[i].d; rsp_ready = tbl[i].rr;
      @(negedge clk);
      chk($sformatf("vec%0d_ready", i), 32'(req_ready), 32'(tbl[i].e_ready));
      chk($sformatf("vec%0d_csn", i), 32'(mem_csn), 32'(tbl[i].e_csn));
      chk($sformatf("vec%0d_rvalid", i), 32'(rsp_valid), 32'(tbl[i].e_rv));
      chk($sformatf("vec%0d_rdata", i), 32'(rsp_rdata), 32'(tbl[i].e_rd));
      @(posedge clk); #1;
    end
    req_valid = 0; rsp_ready = 0;

    // Reset with a response pending: drops immediately, RAM kept
    req_valid = 1; req_we = 0; req_addr = 4'd3;
    @(posedge clk); #1;
    req_valid = 0;
    chk("pend_valid", 32'(rsp_valid), 32'(1));
    chk("pend_data", 32'(rsp_rdata), 32'(8'hA5));
    rstn = 0;
    #1;
    chk("midrst_rvalid", 32'(rsp_valid), 32'(0));
    chk("midrst_rdata", 32'(rsp_rdata), 32'(0));
    chk("midrst_ready", 32'(req_ready), 32'(0));
    repeat (2) @(posedge clk);
    #1 rstn = 1;
    wait_ready(40, "ready_after_midrst");
    @(posedge clk); #1;
`ifdef SPRAM_CTRL_INIT_EN
    single_read(4'd3, IV, "ram_after_rst");

    // Reset while the init sequencer is at address 6
    rstn = 0;
    repeat (2) @(posedge clk);
    #1 rstn = 1;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(posedge clk); #1;
      if (m_state == 1 && m_init_idx == 6) found = 1;
    end
    chk("init_reach6", 32'(found), 32'(1));
    chk("init_addr6", 32'(mem_addr), 32'(6));
    rstn = 0;
    #1;
    chk("initrst_csn", 32'(mem_csn), 32'(1));
    chk("initrst_rvalid", 32'(rsp_valid), 32'(0));
    repeat (2) @(posedge clk);
    #1 rstn = 1;
    wait_ready(40, "reinit_done");
    chk("reinit_write_count", 32'(m_init_writes), 32'(DEPTH));
    @(posedge clk); #1;
`else
    single_read(4'd3, 8'hA5, "ram_after_rst");
`endif

    // Randomized traffic checked by the reference model
    for (int i = 0; i < 600; i++) begin
      req_valid = ($urandom_range(0, 9) < 7);
      req_we    = $urandom_range(0, 1) == 1;
      req_addr  = AW'($urandom_range(0, DEPTH - 1));
      req_wdata = DW'($urandom);
      rsp_ready = ($urandom_range(0, 9) < 6);
      @(posedge clk); #1;
    end
    req_valid = 0; rsp_ready = 1;
    repeat (4) @(posedge clk);
    #1;
    chk("drain_empty", 32'(rsp_valid), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
